fetch1: RTL and testbench
=========================

Name: fetch1

Overview:
- First fetch stage. Owns the architectural fetch PC and issues the virtual fetch address to the TLB/ICache lookup.
- Each cycle it hands the PC and a kill flag to fetch2. fetch2 latches these into its pc_pass/clear_pass registers.
- Applies redirects from exceptions and branches. Buffers a redirect that arrives while the pipe is stalled, so it is never lost.
- Flags misaligned fetch addresses (ADEF) for the exception path.

Parameters:
- RESET_PC, 32'h1C00_0000, PC loaded on reset.
- PC_STEP, 4, increment per sequential fetch (one 32-bit instruction per cycle).

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold request from hazard unit/fetch2; same signal that drives fetch2's stall.
- icache_ready  in  1  ICache can accept a lookup this cycle; 0 acts as an internal stall.
- exc_valid  in  1  exception/ertn redirect request (one-cycle pulse).
- exc_target  in  32  exception redirect target.
- br_taken  in  1  branch/jump mispredict redirect from EX (one-cycle pulse).
- br_target  in  32  branch redirect target.
- pc  out  32  PC of the fetch in flight; to fetch2 "pc".
- clear  out  1  kill current slot; to fetch2 "clear".
- v_addr  out  32  virtual fetch address to TLB/ICache (equals pc).
- v_addr_valid  out  1  lookup request valid.
- exc_adef  out  1  fetch address misaligned (pc[1:0] != 0).
- stall_out  out  1  fetch1 holding (stall | ~icache_ready), for the hazard unit.

Behaviour:
- State register fetch_pc (32b) plus pending slot: pend_valid, pend_is_exc, pend_target[31:0].
- FSM states, 2b encoded:
  - RUN: no redirect pending.
  - HOLD_REDIR: redirect buffered during a hold.
- hold = stall | ~icache_ready.
- Redirect source priority, highest first:
  1. exc_valid
  2. br_taken
  3. pending slot
  - Exception rule: a buffered exception is never overwritten by br_taken. A new exc_valid overwrites any pending entry.
- RUN, hold=0:
  - Redirect present: fetch_pc <= selected target; clear=1 this cycle.
  - Otherwise: fetch_pc <= fetch_pc + PC_STEP, 32-bit wrap (32'hFFFF_FFFC -> 32'h0000_0000).
- RUN, hold=1:
  - fetch_pc holds.
  - A redirect loads the pending slot and goes to HOLD_REDIR; clear=1 that cycle.
- HOLD_REDIR, hold=1:
  - fetch_pc holds; clear=1 every cycle.
  - A new redirect updates the pending slot per the exception rule above.
- HOLD_REDIR, hold=0:
  - fetch_pc <= pending target, or a new higher-priority redirect's target.
  - Clear pend_valid; return to RUN; clear=1.
- Outputs, all combinational from state/inputs:
  - pc = v_addr = fetch_pc.
  - v_addr_valid = ~rst & ~clear.
  - exc_adef = (fetch_pc[1:0] != 2'b00) & ~clear.
  - stall_out = hold.
- Latency: redirect at cycle T (not held) -> pc = target at T+1. Redirect at T while held until T+k -> pc = target at T+k+1.
- Reset, taking effect mid-operation or otherwise:
  - fetch_pc <= RESET_PC; pend_valid <= 0; state <= RUN.
  - During rst: clear=1, v_addr_valid=0.
  - First cycle after rst deasserts: pc = RESET_PC, clear=0.
  - rst overrides hold and all redirects.
- Misaligned targets are accepted as-is. ADEF is reported and the PC still advances by PC_STEP. The exception unit's later exc_valid resolves it.

Decomposition:
- Shared pipeline package: RESET_PC default, PC_STEP, 2-bit FSM state encodings (RUN, HOLD_REDIR), redirect priority constants.
- One natural sub-module: fetch1_redirect_sel. It is combinational: priority select of exc/br/pending, producing next target, pend update, and redirect-present flag.
- PC register and FSM stay in fetch1.

Test Plan:
- Reset then 4 free cycles, no hold -> pc = 1C000000, 1C000004, 1C000008, 1C00000C; clear=0; exc_adef=0.
- br_taken=1, br_target=1C000100 at pc=1C000008 -> clear=1 that cycle; next pc = 1C000100, then 1C000104.
- stall=1 for 3 cycles; br_taken pulse in the 1st of them -> pc frozen; clear=1 all 3 cycles; pc = target on the first cycle after stall drops.
- Held with buffered exception (exc_target=1C008000), then br_taken during the same hold -> pc = 1C008000 after release (exception kept).
- Simultaneous exc_valid and br_taken, no hold -> pc = exc_target next cycle.
- br_target = 1C000102 -> next cycle exc_adef=1, v_addr=1C000102. fetch_pc = FFFFFFFC, no redirect -> next pc = 00000000. rst asserted mid-hold with pending entry -> pc = 1C000000 and pending discarded.

Source files
------------

// File: rtl/fetch1_pkg.sv
// Shared definitions for the first fetch stage: reset PC, PC step,
// FSM state encodings and redirect-source priority codes.
package fetch1_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_HOLD_REDIR = 2'b01
  } fetch1_state_e;

  // Redirect sources, listed from highest to lowest priority
  localparam logic [1:0] REDIR_SRC_EXC  = 2'd0;
  localparam logic [1:0] REDIR_SRC_BR   = 2'd1;
  localparam logic [1:0] REDIR_SRC_PEND = 2'd2;
  localparam logic [1:0] REDIR_SRC_NONE = 2'd3;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc, input logic [31:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch1_redirect_sel.sv
// Combinational redirect arbiter: merges a new exception/branch request with
// the buffered pending entry and reports the winning target.
module fetch1_redirect_sel
  import fetch1_pkg::*;
(
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        pend_valid,
  input  logic        pend_is_exc,
  input  logic [31:0] pend_target,
  output logic        redirect,
  output logic        sel_is_exc,
  output logic [31:0] sel_target
);

  logic [1:0] src_s;
  logic       exc_locked_s;

  assign exc_locked_s = pend_valid & pend_is_exc;

  // Pick the winning source; a buffered exception shields itself from branches
  always_comb begin
    src_s = REDIR_SRC_NONE;
    if (exc_valid) begin
      src_s = REDIR_SRC_EXC;
    end else if (br_taken && !exc_locked_s) begin
      src_s = REDIR_SRC_BR;
    end else if (pend_valid) begin
      src_s = REDIR_SRC_PEND;
    end else begin
      src_s = REDIR_SRC_NONE;
    end
  end

  // Drive the merged entry from the selected source
  always_comb begin
    redirect   = 1'b1;
    sel_is_exc = pend_is_exc;
    sel_target = pend_target;
    case (src_s)
      REDIR_SRC_EXC: begin
        sel_is_exc = 1'b1;
        sel_target = exc_target;
      end
      REDIR_SRC_BR: begin
        sel_is_exc = 1'b0;
        sel_target = br_target;
      end
      REDIR_SRC_PEND: begin
        sel_is_exc = pend_is_exc;
        sel_target = pend_target;
      end
      default: begin
        redirect = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch1.sv
// First fetch stage: owns the fetch PC, applies exception/branch redirects
// (buffering them across holds) and issues the virtual fetch address.
module fetch1
  import fetch1_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        icache_ready,
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] pc,
  output logic        clear,
  output logic [31:0] v_addr,
  output logic        v_addr_valid,
  output logic        exc_adef,
  output logic        stall_out
);

  fetch1_state_e state_r, state_next_s;
  logic [31:0]   fetch_pc_r, fetch_pc_next_s;
  logic          pend_valid_r, pend_valid_next_s;
  logic          pend_is_exc_r, pend_is_exc_next_s;
  logic [31:0]   pend_target_r, pend_target_next_s;
  logic          hold_s, redirect_s, sel_is_exc_s, clear_s;
  logic [31:0]   sel_target_s;

  assign hold_s = stall | ~icache_ready;

  fetch1_redirect_sel u_redirect_sel (
    .exc_valid   (exc_valid),
    .exc_target  (exc_target),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .pend_valid  (pend_valid_r),
    .pend_is_exc (pend_is_exc_r),
    .pend_target (pend_target_r),
    .redirect    (redirect_s),
    .sel_is_exc  (sel_is_exc_s),
    .sel_target  (sel_target_s)
  );

  // Next-state, next-PC and pending-slot update
  always_comb begin
    state_next_s       = state_r;
    fetch_pc_next_s    = fetch_pc_r;
    pend_valid_next_s  = pend_valid_r;
    pend_is_exc_next_s = pend_is_exc_r;
    pend_target_next_s = pend_target_r;
    clear_s            = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (hold_s) begin
          if (redirect_s) begin
            pend_valid_next_s  = 1'b1;
            pend_is_exc_next_s = sel_is_exc_s;
            pend_target_next_s = sel_target_s;
            state_next_s       = ST_HOLD_REDIR;
            clear_s            = 1'b1;
          end else begin
            clear_s = 1'b0;
          end
        end else if (redirect_s) begin
          fetch_pc_next_s = sel_target_s;
          clear_s         = 1'b1;
        end else begin
          fetch_pc_next_s = next_seq_pc(fetch_pc_r, PC_STEP);
        end
      end
      ST_HOLD_REDIR: begin
        clear_s = 1'b1;
        if (hold_s) begin
          pend_valid_next_s  = 1'b1;
          pend_is_exc_next_s = sel_is_exc_s;
          pend_target_next_s = sel_target_s;
        end else begin
          fetch_pc_next_s   = sel_target_s;
          pend_valid_next_s = 1'b0;
          state_next_s      = ST_RUN;
        end
      end
      default: begin
        state_next_s      = ST_RUN;
        pend_valid_next_s = 1'b0;
        clear_s           = 1'b1;
      end
    endcase
  end

  // State, PC and pending-slot registers; reset overrides hold and redirects
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_RUN;
      fetch_pc_r    <= RESET_PC;
      pend_valid_r  <= 1'b0;
      pend_is_exc_r <= 1'b0;
      pend_target_r <= 32'h0000_0000;
    end else begin
      state_r       <= state_next_s;
      fetch_pc_r    <= fetch_pc_next_s;
      pend_valid_r  <= pend_valid_next_s;
      pend_is_exc_r <= pend_is_exc_next_s;
      pend_target_r <= pend_target_next_s;
    end
  end

  assign pc           = fetch_pc_r;
  assign v_addr       = fetch_pc_r;
  assign clear        = rst | clear_s;
  assign v_addr_valid = ~rst & ~clear;
  assign exc_adef     = (fetch_pc_r[1:0] != 2'b00) & ~clear;
  assign stall_out    = hold_s;

endmodule

// File: tb/tb_fetch1.sv
// Self-checking bench for fetch1: directed scenarios plus a randomized run,
// all checked against a cycle-level behavioural model of the fetch rules.
module tb_fetch1;

  localparam logic [31:0] RST_PC = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        rst, stall, icache_ready, exc_valid, br_taken;
  logic [31:0] exc_target, br_target;
  logic [31:0] pc, v_addr;
  logic        clear, v_addr_valid, exc_adef, stall_out;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: architectural PC plus a single pending redirect
  logic [31:0] m_pc = 32'h0;
  bit          m_known = 1'b0;
  bit          m_pv = 1'b0, m_pe = 1'b0;
  logic [31:0] m_pt = 32'h0;

  logic [31:0] e_pc;
  logic        e_clear, e_vav, e_adef, e_stall;

  fetch1 dut (
    .clk(clk), .rst(rst), .stall(stall), .icache_ready(icache_ready),
    .exc_valid(exc_valid), .exc_target(exc_target),
    .br_taken(br_taken), .br_target(br_target),
    .pc(pc), .clear(clear), .v_addr(v_addr), .v_addr_valid(v_addr_valid),
    .exc_adef(exc_adef), .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  // Apply inputs mid-low-phase and compute the model's expected outputs
  task automatic set_in(input logic r, input logic s, input logic rdy,
                        input logic ev, input logic [31:0] et,
                        input logic bv, input logic [31:0] bt);
    rst = r; stall = s; icache_ready = rdy;
    exc_valid = ev; exc_target = et; br_taken = bv; br_target = bt;
    #1;
    e_pc    = m_pc;
    e_clear = r | ev | bv | m_pv;
    e_vav   = ~e_clear;
    e_adef  = (m_pc[1:0] != 2'b00) & ~e_clear;
    e_stall = s | ~rdy;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Clock edge: advance the model using the inputs that were applied
  task automatic tick();
    bit          wv, we;
    logic [31:0] wt;
    @(posedge clk);
    if (rst) begin
      m_pc = RST_PC; m_pv = 1'b0; m_known = 1'b1;
    end else begin
      wv = 1'b1; we = 1'b0; wt = 32'h0;
      if (exc_valid) begin we = 1'b1; wt = exc_target; end
      else if (br_taken && !(m_pv && m_pe)) begin we = 1'b0; wt = br_target; end
      else if (m_pv) begin we = m_pe; wt = m_pt; end
      else wv = 1'b0;
      if (stall || !icache_ready) begin
        if (wv) begin m_pv = 1'b1; m_pe = we; m_pt = wt; end
      end else if (wv) begin
        m_pc = wt; m_pv = 1'b0;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
      n_cmp++;
      if ({clear, v_addr_valid} !== 2'b10) begin
        n_fail++;
        $display("FAIL reset_outputs: clear/v_addr_valid got %b%b required 10", clear, v_addr_valid);
      end
      tick();
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      idle();
      n_cmp++;
      if (pc !== RST_PC + 32'(4 * i) || clear !== 1'b0 || exc_adef !== 1'b0 || v_addr_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL sequential[%0d]: pc=%h clear=%b adef=%b vav=%b required pc=%h clear=0 adef=0 vav=1",
                 i, pc, clear, exc_adef, v_addr_valid, RST_PC + 32'(4 * i));
      end
      tick();
    end
  endtask

  task automatic test_branch();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1C00_0100);
    n_cmp++;
    if (clear !== 1'b1 || v_addr_valid !== 1'b0) begin
      n_fail++; $display("FAIL branch_clear: clear=%b vav=%b required clear=1 vav=0", clear, v_addr_valid);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      idle();
      n_cmp++;
      if (pc !== 32'h1C00_0100 + 32'(4 * i) || clear !== 1'b0) begin
        n_fail++; $display("FAIL branch_pc[%0d]: pc=%h clear=%b required pc=%h clear=0", i, pc, clear, 32'h1C00_0100 + 32'(4 * i));
      end
      tick();
    end
  endtask

  task automatic test_stall_redirect();
    logic [31:0] frozen;
    frozen = m_pc;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, (i == 0), 32'h1C00_0200);
      n_cmp++;
      if (pc !== frozen || clear !== 1'b1 || stall_out !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: pc=%h clear=%b stall_out=%b required pc=%h clear=1 stall_out=1", i, pc, clear, stall_out, frozen);
      end
      tick();
    end
    idle();
    n_cmp++;
    if (clear !== 1'b1 || stall_out !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: clear=%b stall_out=%b required clear=1 stall_out=0", clear, stall_out);
    end
    tick();
    idle();
    n_cmp++;
    if (pc !== 32'h1C00_0200 || clear !== 1'b0) begin
      n_fail++; $display("FAIL stall_target: pc=%h clear=%b required pc=1c000200 clear=0", pc, clear);
    end
    tick();
  endtask

  task automatic test_exc_kept();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h1C00_8000, 1'b0, 32'h0);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1C00_0300);
    n_cmp++;
    if (clear !== 1'b1 || pc !== e_pc) begin
      n_fail++; $display("FAIL exc_hold: pc=%h clear=%b required pc=%h clear=1", pc, clear, e_pc);
    end
    tick();
    idle(); tick();
    idle();
    n_cmp++;
    if (pc !== 32'h1C00_8000) begin
      n_fail++; $display("FAIL exc_kept: pc=%h required 1c008000", pc);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 32'h1C00_9000, 1'b1, 32'h1C00_0400);
    tick();
    idle();
    n_cmp++;
    if (pc !== 32'h1C00_9000 || clear !== 1'b0) begin
      n_fail++; $display("FAIL exc_over_br: pc=%h clear=%b required pc=1c009000 clear=0", pc, clear);
    end
    tick();
  endtask

  task automatic test_misaligned_wrap();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1C00_0102);
    n_cmp++;
    if (exc_adef !== 1'b0) begin
      n_fail++; $display("FAIL adef_masked: exc_adef=%b required 0 while clearing", exc_adef);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      idle();
      n_cmp++;
      if (v_addr !== 32'h1C00_0102 + 32'(4 * i) || exc_adef !== 1'b1) begin
        n_fail++; $display("FAIL adef[%0d]: v_addr=%h exc_adef=%b required v_addr=%h adef=1", i, v_addr, exc_adef, 32'h1C00_0102 + 32'(4 * i));
      end
      tick();
    end
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    tick();
    idle(); tick();
    idle();
    n_cmp++;
    if (pc !== 32'h0000_0000 || exc_adef !== 1'b0) begin
      n_fail++; $display("FAIL wrap: pc=%h adef=%b required pc=00000000 adef=0", pc, exc_adef);
    end
    tick();
  endtask

  task automatic test_reset_mid_hold();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1C00_0500);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h1C00_A000, 1'b0, 32'h0);
    n_cmp++;
    if (clear !== 1'b1 || v_addr_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_clear: clear=%b vav=%b required clear=1 vav=0", clear, v_addr_valid);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      idle();
      n_cmp++;
      if (pc !== RST_PC + 32'(4 * i) || clear !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_pc[%0d]: pc=%h clear=%b required pc=%h clear=0", i, pc, clear, RST_PC + 32'(4 * i));
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic        r, s, rdy, ev, bv;
    logic [31:0] et, bt;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 25);
      rdy = ($urandom_range(0, 99) >= 15);
      ev  = ($urandom_range(0, 99) < 6);
      bv  = ($urandom_range(0, 99) < 12);
      et  = {$urandom_range(0, 65535), 16'h0} | 32'({$urandom_range(0, 255), 2'b00});
      bt  = $urandom;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      set_in(r, s, rdy, ev, et, bv, bt);
      n_cmp++;
      if ({pc, v_addr, clear, v_addr_valid, exc_adef, stall_out} !== {e_pc, e_pc, e_clear, e_vav, e_adef, e_stall}) begin
        n_fail++;
        $display("FAIL random[%0d]: pc=%h va=%h clr=%b vav=%b adef=%b so=%b required pc=%h clr=%b vav=%b adef=%b so=%b",
                 i, pc, v_addr, clear, v_addr_valid, exc_adef, stall_out, e_pc, e_clear, e_vav, e_adef, e_stall);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; icache_ready = 1'b1;
    exc_valid = 1'b0; br_taken = 1'b0; exc_target = 32'h0; br_target = 32'h0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branch();
    test_stall_redirect();
    test_exc_kept();
    test_simultaneous();
    test_misaligned_wrap();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
